// File: rtl/pat_gen_pkg.sv
// Shared types for the pattern generator controller.
package pat_gen_pkg;

  // Run sequencer states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } pat_state_t;

  // Larger of two widths; sizes the sub-registers so they hold either an
  // address or a base data word.
  function automatic int max_width(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pat_gen_regs.sv
// Pattern sub-register array: one write port, one combinational read port.
module pat_gen_regs #(
  parameter int NUM_REGS = 21,
  parameter int W        = 32,
  parameter int IDX_W    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [W-1:0]     wr_data,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [W-1:0]     rd_data
);

  logic [W-1:0] regs_q [NUM_REGS];

  // Storage: cleared on reset, written when the controller grants a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wr_data;
    end
  end

  // Read mux; indices past the last register read as zero.
  always_comb begin
    rd_data = '0;
    if (int'(rd_idx) < NUM_REGS) begin
      rd_data = regs_q[rd_idx];
    end
  end

endmodule

// File: rtl/pat_gen_ctrl.sv
// Pattern generator controller: sub-register writes while idle, and on a
// rising edge of cfg_pat_gen_i streams all registers out over a
// valid/ready port.
//
// Handshake: a word transfers on a rising clk edge where pat_valid_o and
// pat_ready_i are both high; once pat_valid_o rises, pat_valid_o,
// pat_data_o and pat_idx_o stay constant until that transfer.
module pat_gen_ctrl
  import pat_gen_pkg::*;
#(
  parameter int ADDR_WIDTH          = 32,
  parameter int DATA_WIDTH          = 12,
  parameter int NUM_REGS            = 21,
  parameter int SUB_REGS_DATA_WIDTH = max_width(ADDR_WIDTH, DATA_WIDTH)
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           si_we_i,
  input  logic [ADDR_WIDTH-1:0]          si_addr_i,
  input  logic [SUB_REGS_DATA_WIDTH-1:0] ctl_pat_data_i,
  input  logic                           cfg_pat_gen_i,
  input  logic                           pat_ready_i,
  output logic                           pat_valid_o,
  output logic [SUB_REGS_DATA_WIDTH-1:0] pat_data_o,
  output logic [$clog2(NUM_REGS)-1:0]    pat_idx_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o,
  output logic                           nopg_o
);

  localparam int W     = SUB_REGS_DATA_WIDTH;
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

  pat_state_t       state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             cfg_q, cfg_prev_q;
  logic             start_edge;
  logic             addr_ok;
  logic             wr_grant;
  logic             err_q;
  logic             handshake;
  logic [W-1:0]     rd_data;

  // cfg_q is the registered enable; cfg_prev_q its previous value.
  assign start_edge = cfg_q && !cfg_prev_q;
  assign addr_ok    = (si_addr_i < ADDR_WIDTH'(NUM_REGS));
  assign wr_grant   = si_we_i && addr_ok && (state_q == IDLE);
  assign handshake  = (state_q == STREAM) && pat_ready_i;

  pat_gen_regs #(
    .NUM_REGS (NUM_REGS),
    .W        (W),
    .IDX_W    (IDX_W)
  ) u_regs (
    .clk     (clk_i),
    .rst     (rst_i),
    .wr_en   (wr_grant),
    .wr_idx  (si_addr_i[IDX_W-1:0]),
    .wr_data (ctl_pat_data_i),
    .rd_idx  (idx_q),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state: edges outside IDLE are ignored, cfg dropping never aborts.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_edge) state_d = LOAD;
      LOAD:    state_d = STREAM;
      STREAM:  if (handshake && (idx_q == LAST_IDX)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    pat_valid_o = (state_q == STREAM);
    pat_data_o  = (state_q == STREAM) ? rd_data : '0;
    pat_idx_o   = idx_q;
    busy_o      = (state_q == LOAD) || (state_q == STREAM);
    done_o      = (state_q == DONE);
    nopg_o      = (state_q == IDLE) || (state_q == DONE);
    err_o       = err_q;
  end

  // Enable edge-detect pipeline.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cfg_q      <= 1'b0;
      cfg_prev_q <= 1'b0;
    end else begin
      cfg_q      <= cfg_pat_gen_i;
      cfg_prev_q <= cfg_q;
    end
  end

  // Word index: cleared on LOAD/DONE, advances per transfer, stops at the last register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else if ((state_q == LOAD) || (state_q == DONE)) begin
      idx_q <= '0;
    end else if (handshake && (idx_q != LAST_IDX)) begin
      idx_q <= idx_q + IDX_W'(1);
    end
  end

  // Rejected write (bad address or not idle) gives a one-cycle error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_q <= 1'b0;
    else       err_q <= si_we_i && !(addr_ok && (state_q == IDLE));
  end

endmodule

// File: tb/tb_pat_gen_ctrl.sv
// Bench for pat_gen_ctrl: scoreboard of expected {idx,data} words plus
// per-scenario tasks.
module tb_pat_gen_ctrl;

  localparam int NREG = 21;
  localparam int AW   = 32;
  localparam int W    = 32;
  localparam int IW   = 5;
  localparam int EW   = IW + W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          si_we = 1'b0;
  logic [AW-1:0] si_addr = '0;
  logic [W-1:0]  wdata = '0;
  logic          cfg = 1'b0;
  logic          ready = 1'b1;
  logic          pat_valid;
  logic [W-1:0]  pat_data;
  logic [IW-1:0] pat_idx;
  logic          busy, done, err, nopg;

  logic [EW-1:0] exp_q[$];
  logic [W-1:0]  model [NREG];

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0, done_cnt = 0, err_cnt = 0;

  logic          held_v = 1'b0;
  logic [W-1:0]  held_d = '0;
  logic [IW-1:0] held_i = '0;

  pat_gen_ctrl #(
    .ADDR_WIDTH (AW), .DATA_WIDTH (12), .NUM_REGS (NREG), .SUB_REGS_DATA_WIDTH (W)
  ) dut (
    .clk_i (clk), .rst_i (rst), .si_we_i (si_we), .si_addr_i (si_addr),
    .ctl_pat_data_i (wdata), .cfg_pat_gen_i (cfg), .pat_ready_i (ready),
    .pat_valid_o (pat_valid), .pat_data_o (pat_data), .pat_idx_o (pat_idx),
    .busy_o (busy), .done_o (done), .err_o (err), .nopg_o (nopg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // Monitor: stability while stalled, scoreboard pop on each transfer.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (err)  err_cnt++;
      if (held_v) begin
        total++;
        if (!pat_valid || pat_data !== held_d || pat_idx !== held_i) begin
          bad++;
          $display("FAIL stall_hold got v=%0b idx=%0d data=%0h want v=1 idx=%0d data=%0h",
                   pat_valid, pat_idx, pat_data, held_i, held_d);
        end
      end
      if (pat_valid && ready) begin
        hs_cnt++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL extra_word got idx=%0d data=%0h want none", pat_idx, pat_data);
        end else begin
          logic [EW-1:0] e;
          e = exp_q.pop_front();
          if ({pat_idx, pat_data} !== e) begin
            bad++;
            $display("FAIL word got idx=%0d data=%0h want idx=%0d data=%0h",
                     pat_idx, pat_data, e[EW-1:W], e[W-1:0]);
          end
        end
      end
      held_v = pat_valid && !ready;
      held_d = pat_data;
      held_i = pat_idx;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [AW-1:0] addr, input logic [W-1:0] d, input bit ok);
    si_we = 1'b1; si_addr = addr; wdata = d;
    tick();
    si_we = 1'b0;
    if (ok) model[addr[IW-1:0]] = d;
    total++;
    if (err !== !ok) begin
      bad++;
      $display("FAIL err_after_write addr=%0d got=%0b want=%0b", addr, err, !ok);
    end
  endtask

  task automatic push_run();
    for (int i = 0; i < NREG; i++) exp_q.push_back({IW'(i), model[i]});
  endtask

  task automatic start_run();
    push_run();
    cfg = 1'b1;
    tick();
    cfg = 1'b0;
  endtask

  task automatic wait_done(input string name, input bit toggle);
    bit seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (toggle) ready = ~ready;
      tick();
      if (done) seen = 1'b1;
    end
    ready = 1'b1;
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL %s_done_timeout got=no_done want=done", name);
    end
  endtask

  task automatic wait_idx(input int target);
    bit seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (pat_valid && pat_idx == IW'(target)) seen = 1'b1;
      else tick();
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL wait_idx%0d got=timeout want=word", target);
    end
  endtask

  task automatic check_idle(input string name);
    total++;
    if (!nopg || busy || pat_valid || done || !exp_q.size() == 0) begin
      bad++;
      $display("FAIL %s_idle got nopg=%0b busy=%0b v=%0b done=%0b q=%0d want 1 0 0 0 0",
               name, nopg, busy, pat_valid, done, exp_q.size());
    end
  endtask

  // test_reset: outputs during and after power-on reset
  task automatic test_reset();
    logic [41:0] got, want;
    tick(); tick();
    want = {1'b0, 32'h0, 5'h0, 1'b0, 1'b0, 1'b0, 1'b1};
    got  = {pat_valid, pat_data, pat_idx, busy, done, err, nopg};
    total++;
    if (got !== want) begin bad++; $display("FAIL reset_outputs got=%0h want=%0h", got, want); end
    rst = 1'b0;
    tick();
    got = {pat_valid, pat_data, pat_idx, busy, done, err, nopg};
    total++;
    if (got !== want) begin bad++; $display("FAIL post_reset_outputs got=%0h want=%0h", got, want); end
  endtask

  // test_basic: full run with ready high, cycle-exact timing
  task automatic test_basic();
    int cyc = 0;
    int d0 = done_cnt;
    for (int i = 0; i < NREG; i++) write_reg(AW'(i), W'(32'h100 + i), 1'b1);
    ready = 1'b1;
    start_run();
    tick();
    cyc = 1;
    total++;
    if (!busy || pat_valid || nopg) begin
      bad++; $display("FAIL load_state got busy=%0b v=%0b nopg=%0b want 1 0 0", busy, pat_valid, nopg);
    end
    while (!done && cyc < 60) begin
      tick();
      cyc++;
      if (cyc == 2) begin
        total++;
        if (!pat_valid || pat_idx !== 5'd0 || pat_data !== 32'h100) begin
          bad++; $display("FAIL first_word got v=%0b idx=%0d data=%0h want 1 0 100", pat_valid, pat_idx, pat_data);
        end
      end
    end
    total++;
    if (cyc != NREG + 2 || !done) begin
      bad++; $display("FAIL done_cycle got=%0d want=%0d", cyc, NREG + 2);
    end
    tick();
    check_idle("basic");
    total++;
    if (done_cnt - d0 != 1) begin bad++; $display("FAIL basic_done_count got=%0d want=1", done_cnt - d0); end
  endtask

  // test_backpressure: ready toggling every cycle
  task automatic test_backpressure();
    int h0 = hs_cnt;
    start_run();
    wait_done("bp", 1'b1);
    tick();
    check_idle("bp");
    total++;
    if (hs_cnt - h0 != NREG) begin bad++; $display("FAIL bp_handshakes got=%0d want=%0d", hs_cnt - h0, NREG); end
  endtask

  // test_access_error: bad address and write during streaming
  task automatic test_access_error();
    int e0 = err_cnt;
    write_reg(AW'(NREG), 32'hDEAD, 1'b0);
    tick();
    start_run();
    wait_idx(0);
    write_reg(AW'(3), 32'hABC, 1'b0);
    wait_done("err_run", 1'b0);
    tick();
    total++;
    if (err_cnt - e0 != 2) begin bad++; $display("FAIL err_pulses got=%0d want=2", err_cnt - e0); end
    start_run();
    wait_done("err_rerun", 1'b0);
    tick();
    check_idle("err");
  endtask

  // test_cfg_edges: second edge ignored; cfg drop does not abort
  task automatic test_cfg_edges();
    int d0 = done_cnt;
    int h0 = hs_cnt;
    start_run();
    wait_idx(5);
    cfg = 1'b1;
    tick();
    cfg = 1'b0;
    wait_done("edge2", 1'b0);
    for (int i = 0; i < 6; i++) tick();
    check_idle("edge2");
    total++;
    if (done_cnt - d0 != 1 || hs_cnt - h0 != NREG) begin
      bad++; $display("FAIL edge2_counts got done=%0d hs=%0d want 1 %0d", done_cnt - d0, hs_cnt - h0, NREG);
    end
    d0 = done_cnt;
    h0 = hs_cnt;
    push_run();
    cfg = 1'b1;
    tick();
    wait_idx(5);
    cfg = 1'b0;
    wait_done("cfg_drop", 1'b0);
    tick();
    check_idle("cfg_drop");
    total++;
    if (done_cnt - d0 != 1 || hs_cnt - h0 != NREG) begin
      bad++; $display("FAIL cfg_drop_counts got done=%0d hs=%0d want 1 %0d", done_cnt - d0, hs_cnt - h0, NREG);
    end
  endtask

  // test_reset_mid: reset during streaming, then a zero-data run
  task automatic test_reset_mid();
    int d0;
    start_run();
    wait_idx(10);
    d0 = done_cnt;
    #2;
    rst = 1'b1;
    #1;
    total++;
    if (pat_valid || !nopg || busy || done) begin
      bad++; $display("FAIL mid_reset got v=%0b nopg=%0b busy=%0b done=%0b want 0 1 0 0", pat_valid, nopg, busy, done);
    end
    exp_q.delete();
    for (int i = 0; i < NREG; i++) model[i] = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (done_cnt != d0 || pat_valid) begin
      bad++; $display("FAIL mid_reset_no_done got done=%0d v=%0b want 0 0", done_cnt - d0, pat_valid);
    end
    start_run();
    wait_done("zero_run", 1'b0);
    tick();
    check_idle("zero_run");
  endtask

  // test_write_and_start: write and enable edge in the same cycle
  task automatic test_write_and_start();
    si_we = 1'b1; si_addr = AW'(7); wdata = 32'h5A5;
    model[7] = 32'h5A5;
    cfg = 1'b1;
    push_run();
    tick();
    si_we = 1'b0;
    cfg = 1'b0;
    total++;
    if (err !== 1'b0) begin bad++; $display("FAIL same_cycle_err got=%0b want=0", err); end
    wait_done("same_cycle", 1'b0);
    tick();
    check_idle("same_cycle");
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = '0;
    test_reset();
    test_basic();
    test_backpressure();
    test_access_error();
    test_cfg_edges();
    test_reset_mid();
    test_write_and_start();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
